// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write-port arbiter.
package regfile_pkg;

  // Default widths of the write port.
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;

  // Writes to this index are accepted but never reach the register file.
  localparam logic [4:0] ZERO_REG = 5'd31;

  // Requester indices, used both as grant-vector bit positions and as
  // round-robin pointer values.
  localparam logic REQ_EX  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter: round-robin between EX and MEM, with a
// force input that hands the grant to MEM whenever both are requesting.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       force_mem,
  output logic [1:0] gnt
);

  // Pick at most one requester; single requests always win outright.
  // NOTE: gnt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt[REQ_EX]  = 1'b1;
      2'b10:   gnt[REQ_MEM] = 1'b1;
      2'b11: begin
        if (force_mem || (ptr == REQ_MEM)) begin
          gnt[REQ_MEM] = 1'b1;
        end else begin
          gnt[REQ_EX] = 1'b1;
        end
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the EX and MEM writeback
// requesters. Grants are round-robin except on a same-register conflict,
// where MEM (the older instruction) wins. The winning write is registered
// and presented to the register file for one cycle; committed writes are
// counted in a wrapping 16-bit counter.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Hold,
  input  logic              ExValid,
  output logic              ExReady,
  input  logic [ADDR_W-1:0] ExRW,
  input  logic [DATA_W-1:0] ExBusW,
  input  logic              MemValid,
  output logic              MemReady,
  input  logic [ADDR_W-1:0] MemRW,
  input  logic [DATA_W-1:0] MemBusW,
  output logic              RegWr,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  output logic [15:0]       WrCnt
);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_force_mem;
  logic              w_transfer;
  logic              w_win_is_mem;
  logic              w_win_commit;
  logic [ADDR_W-1:0] w_win_rw;
  logic [DATA_W-1:0] w_win_data;

  logic              r_rr_ptr;
  logic              r_reg_wr;
  logic [ADDR_W-1:0] r_rw;
  logic [DATA_W-1:0] r_bus_w;
  logic [15:0]       r_wr_cnt;

  // Reset and stall both suppress every request before arbitration, so
  // Ready stays low and nothing moves while either is active.
  assign w_req       = {MemValid, ExValid} & {2{Rst_n & ~Hold}};
  assign w_force_mem = (ExRW == MemRW);

  rr_arb2 u_arb (
    .req       (w_req),
    .ptr       (r_rr_ptr),
    .force_mem (w_force_mem),
    .gnt       (w_gnt)
  );

  assign ExReady  = w_gnt[REQ_EX];
  assign MemReady = w_gnt[REQ_MEM];

  // Winner selection. A write to the zero register completes the handshake
  // but is not committed.
  assign w_transfer   = |w_gnt;
  assign w_win_is_mem = w_gnt[REQ_MEM];
  assign w_win_rw     = w_win_is_mem ? MemRW   : ExRW;
  assign w_win_data   = w_win_is_mem ? MemBusW : ExBusW;
  assign w_win_commit = w_transfer && (w_win_rw != ADDR_W'(ZERO_REG));

  // Round-robin pointer: after any grant, the other requester gets priority.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_rr_ptr <= REQ_EX;
    end else if (w_transfer) begin
      r_rr_ptr <= w_win_is_mem ? REQ_EX : REQ_MEM;
    end
  end

  // Output register: RegWr pulses for one cycle per committed write; RW and
  // BusW hold their last values between transfers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_reg_wr <= 1'b0;
      r_rw     <= '0;
      r_bus_w  <= '0;
    end else begin
      r_reg_wr <= w_win_commit;
      if (w_transfer) begin
        r_rw    <= w_win_rw;
        r_bus_w <= w_win_data;
      end
    end
  end

  // Committed-write counter, advanced on the same edge that registers RegWr=1.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_wr_cnt <= '0;
    end else if (w_win_commit) begin
      r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign RegWr = r_reg_wr;
  assign RW    = r_rw;
  assign BusW  = r_bus_w;
  assign WrCnt = r_wr_cnt;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus a
// randomized run compared against a behavioural model of the grant rules,
// the output register, the counter and the register file it feeds.
module tb_regfile_wr_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Hold;
  logic        ExValid;
  logic        ExReady;
  logic [4:0]  ExRW;
  logic [63:0] ExBusW;
  logic        MemValid;
  logic        MemReady;
  logic [4:0]  MemRW;
  logic [63:0] MemBusW;
  logic        RegWr;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic [15:0] WrCnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  logic        m_ptr;
  logic        m_regwr;
  logic [4:0]  m_rw;
  logic [63:0] m_busw;
  logic [15:0] m_cnt;
  logic [63:0] m_rf [32];

  // Register file driven by the DUT, written on the falling edge.
  logic [63:0] tb_rf [32];

  regfile_wr_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Hold     (Hold),
    .ExValid  (ExValid),
    .ExReady  (ExReady),
    .ExRW     (ExRW),
    .ExBusW   (ExBusW),
    .MemValid (MemValid),
    .MemReady (MemReady),
    .MemRW    (MemRW),
    .MemBusW  (MemBusW),
    .RegWr    (RegWr),
    .RW       (RW),
    .BusW     (BusW),
    .WrCnt    (WrCnt)
  );

  initial forever #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (RegWr === 1'b1) tb_rf[RW] <= BusW;
  end

  // Expected grant {mem, ex} from the current inputs and the model pointer.
  function automatic logic [1:0] exp_grant();
    if (!Rst_n || Hold)               return 2'b00;
    if (ExValid && MemValid) begin
      if (ExRW == MemRW)              return 2'b10;
      return m_ptr ? 2'b10 : 2'b01;
    end
    if (ExValid)                      return 2'b01;
    if (MemValid)                     return 2'b10;
    return 2'b00;
  endfunction

  // Advance the model across one rising edge given the grant decided before it.
  task automatic model_apply(input logic [1:0] g);
    logic [4:0]  r;
    logic [63:0] d;
    if (!Rst_n) begin
      m_regwr = 1'b0; m_rw = '0; m_busw = '0; m_ptr = 1'b0; m_cnt = '0;
    end else if (g == 2'b00) begin
      m_regwr = 1'b0;
    end else begin
      r = g[1] ? MemRW   : ExRW;
      d = g[1] ? MemBusW : ExBusW;
      m_rw    = r;
      m_busw  = d;
      m_regwr = (r != 5'd31);
      if (m_regwr) begin
        m_cnt = m_cnt + 16'd1;
        m_rf[r] = d;
      end
      m_ptr = g[1] ? 1'b0 : 1'b1;
    end
  endtask

  // One clock: decide the expected grant, cross the edge, update the model,
  // and leave time 1 ns after the edge for sampling and driving.
  task automatic step(output logic [1:0] g);
    g = exp_grant();
    @(posedge Clk);
    model_apply(g);
    #1;
  endtask

  task automatic do_reset();
    logic [1:0] g;
    Rst_n = 1'b0; Hold = 1'b0; ExValid = 1'b0; MemValid = 1'b0;
    step(g);
    step(g);
    Rst_n = 1'b1;
  endtask

  task automatic idle();
    logic [1:0] g;
    ExValid = 1'b0; MemValid = 1'b0; Hold = 1'b0;
    step(g);
  endtask

  task automatic test_reset();
    logic [1:0] g;
    ExValid = 1'b1; ExRW = 5'd4; ExBusW = 64'h1111;
    MemValid = 1'b1; MemRW = 5'd5; MemBusW = 64'h2222;
    Hold = 1'b0; Rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if ({MemReady, ExReady} !== 2'b00) begin
        n_fail++; $display("FAIL reset_ready cyc=%0d got=%b exp=00", i, {MemReady, ExReady});
      end
      step(g);
      n_tests++;
      if (RegWr !== 1'b0 || WrCnt !== 16'd0) begin
        n_fail++; $display("FAIL reset_regs cyc=%0d RegWr=%b WrCnt=%0d exp 0/0", i, RegWr, WrCnt);
      end
    end
    n_tests++;
    if (RW !== 5'd0 || BusW !== 64'd0) begin
      n_fail++; $display("FAIL reset_rw_busw got RW=%0d BusW=%h exp 0/0", RW, BusW);
    end
    Rst_n = 1'b1;
    #1;
    n_tests++;
    if ({MemReady, ExReady} !== 2'b01) begin
      n_fail++; $display("FAIL reset_first_grant got=%b exp=01", {MemReady, ExReady});
    end
    step(g);
    ExValid = 1'b0;
    n_tests++;
    if (RegWr !== 1'b1 || RW !== 5'd4 || BusW !== 64'h1111) begin
      n_fail++; $display("FAIL reset_first_write got RegWr=%b RW=%0d BusW=%h exp 1/4/1111", RegWr, RW, BusW);
    end
    idle();
  endtask

  task automatic test_single_write();
    logic [1:0] g;
    do_reset();
    ExValid = 1'b1; ExRW = 5'd3; ExBusW = 64'h0123456789ABCDEF;
    #1;
    n_tests++;
    if ({MemReady, ExReady} !== 2'b01) begin
      n_fail++; $display("FAIL single_ready got=%b exp=01", {MemReady, ExReady});
    end
    step(g);
    ExValid = 1'b0;
    n_tests++;
    if (RegWr !== 1'b1 || RW !== 5'd3 || BusW !== 64'h0123456789ABCDEF || WrCnt !== 16'd1) begin
      n_fail++; $display("FAIL single_out got RegWr=%b RW=%0d BusW=%h WrCnt=%0d exp 1/3/0123456789abcdef/1",
                         RegWr, RW, BusW, WrCnt);
    end
    @(negedge Clk); #1;
    n_tests++;
    if (tb_rf[3] !== 64'h0123456789ABCDEF) begin
      n_fail++; $display("FAIL single_rf got=%h exp=0123456789abcdef", tb_rf[3]);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    logic [1:0] exp_g;
    logic [4:0] exp_rw;
    do_reset();
    ExValid = 1'b1; ExRW = 5'd1; ExBusW = {$urandom, $urandom};
    MemValid = 1'b1; MemRW = 5'd2; MemBusW = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      exp_g  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_rw = (i % 2 == 0) ? 5'd1 : 5'd2;
      #1;
      n_tests++;
      if ({MemReady, ExReady} !== exp_g) begin
        n_fail++; $display("FAIL rr_grant i=%0d got=%b exp=%b", i, {MemReady, ExReady}, exp_g);
      end
      step(g);
      n_tests++;
      if (RegWr !== 1'b1 || RW !== exp_rw || BusW !== m_busw) begin
        n_fail++; $display("FAIL rr_out i=%0d got RegWr=%b RW=%0d BusW=%h exp 1/%0d/%h", i, RegWr, RW, BusW, exp_rw, m_busw);
      end
      if (g[0]) ExBusW  = {$urandom, $urandom};
      if (g[1]) MemBusW = {$urandom, $urandom};
    end
    idle();
    idle();
  endtask

  task automatic test_conflict();
    logic [1:0] g;
    do_reset();
    ExValid = 1'b1; ExRW = 5'd7; ExBusW = 64'hE0E0_E0E0_0000_0007;
    MemValid = 1'b1; MemRW = 5'd7; MemBusW = 64'hA5A5_A5A5_0000_0007;
    #1;
    n_tests++;
    if ({MemReady, ExReady} !== 2'b10) begin
      n_fail++; $display("FAIL conflict_grant got=%b exp=10", {MemReady, ExReady});
    end
    step(g);
    MemValid = 1'b0;
    n_tests++;
    if (RegWr !== 1'b1 || RW !== 5'd7 || BusW !== 64'hA5A5_A5A5_0000_0007) begin
      n_fail++; $display("FAIL conflict_mem_out got RegWr=%b RW=%0d BusW=%h exp 1/7/a5a5a5a500000007", RegWr, RW, BusW);
    end
    #1;
    n_tests++;
    if ({MemReady, ExReady} !== 2'b01) begin
      n_fail++; $display("FAIL conflict_ex_next got=%b exp=01", {MemReady, ExReady});
    end
    step(g);
    ExValid = 1'b0;
    n_tests++;
    if (BusW !== 64'hE0E0_E0E0_0000_0007) begin
      n_fail++; $display("FAIL conflict_ex_out got=%h exp=e0e0e0e000000007", BusW);
    end
    @(negedge Clk); #1;
    n_tests++;
    if (tb_rf[7] !== 64'hE0E0_E0E0_0000_0007) begin
      n_fail++; $display("FAIL conflict_rf7 got=%h exp=e0e0e0e000000007", tb_rf[7]);
    end
  endtask

  task automatic test_zero_reg();
    logic [1:0]  g;
    logic [15:0] cnt0;
    idle();
    cnt0 = m_cnt;
    MemValid = 1'b1; MemRW = 5'd31; MemBusW = 64'hFF;
    #1;
    n_tests++;
    if ({MemReady, ExReady} !== 2'b10) begin
      n_fail++; $display("FAIL zero_ready got=%b exp=10", {MemReady, ExReady});
    end
    step(g);
    MemValid = 1'b0;
    n_tests++;
    if (RegWr !== 1'b0 || WrCnt !== cnt0) begin
      n_fail++; $display("FAIL zero_out got RegWr=%b WrCnt=%0d exp 0/%0d", RegWr, WrCnt, cnt0);
    end
    @(negedge Clk); #1;
    n_tests++;
    if (tb_rf[31] !== 64'd0) begin
      n_fail++; $display("FAIL zero_rf31 got=%h exp=0", tb_rf[31]);
    end
  endtask

  task automatic test_hold();
    logic [1:0] g;
    idle();
    ExValid = 1'b1; ExRW = 5'd9; ExBusW = 64'h9999_0000_9999;
    Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (ExReady !== 1'b0) begin
        n_fail++; $display("FAIL hold_ready i=%0d got=%b exp=0", i, ExReady);
      end
      step(g);
      n_tests++;
      if (RegWr !== 1'b0) begin
        n_fail++; $display("FAIL hold_regwr i=%0d got=%b exp=0", i, RegWr);
      end
    end
    Hold = 1'b0;
    #1;
    n_tests++;
    if (ExReady !== 1'b1) begin
      n_fail++; $display("FAIL hold_release_ready got=%b exp=1", ExReady);
    end
    step(g);
    ExValid = 1'b0;
    n_tests++;
    if (RegWr !== 1'b1 || RW !== 5'd9 || BusW !== 64'h9999_0000_9999) begin
      n_fail++; $display("FAIL hold_release_out got RegWr=%b RW=%0d BusW=%h exp 1/9/999900009999", RegWr, RW, BusW);
    end
  endtask

  function automatic logic [4:0] pick_rw();
    case ($urandom_range(0, 4))
      0:       return 5'd5;
      1:       return 5'd6;
      2:       return 5'd7;
      3:       return 5'd31;
      default: return 5'($urandom_range(0, 30));
    endcase
  endfunction

  task automatic test_random();
    logic [1:0] g;
    logic [1:0] eg;
    logic       ex_pend;
    logic       mem_pend;
    ex_pend = 1'b0; mem_pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      Hold  = ($urandom_range(0, 9) == 0);
      Rst_n = ($urandom_range(0, 49) != 0);
      if (!ex_pend && $urandom_range(0, 2) != 0) begin
        ex_pend = 1'b1; ExRW = pick_rw(); ExBusW = {$urandom, $urandom};
      end
      if (!mem_pend && $urandom_range(0, 2) != 0) begin
        mem_pend = 1'b1; MemRW = pick_rw(); MemBusW = {$urandom, $urandom};
      end
      ExValid = ex_pend; MemValid = mem_pend;
      #1;
      eg = exp_grant();
      n_tests++;
      if ({MemReady, ExReady} !== eg) begin
        n_fail++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, {MemReady, ExReady}, eg);
      end
      step(g);
      if (g[0]) ex_pend = 1'b0;
      if (g[1]) mem_pend = 1'b0;
      n_tests++;
      if (RegWr !== m_regwr || RW !== m_rw || BusW !== m_busw || WrCnt !== m_cnt) begin
        n_fail++; $display("FAIL rnd_out i=%0d got %b/%0d/%h/%0d exp %b/%0d/%h/%0d",
                           i, RegWr, RW, BusW, WrCnt, m_regwr, m_rw, m_busw, m_cnt);
      end
    end
    Rst_n = 1'b1;
    idle();
    @(negedge Clk); #1;
    for (int r = 0; r < 32; r++) begin
      n_tests++;
      if (tb_rf[r] !== m_rf[r]) begin
        n_fail++; $display("FAIL rnd_rf reg=%0d got=%h exp=%h", r, tb_rf[r], m_rf[r]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] g;
    do_reset();
    ExValid = 1'b1; ExRW = 5'd1;
    for (int i = 0; i < 65535; i++) begin
      ExBusW = 64'(i);
      step(g);
    end
    n_tests++;
    if (WrCnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_max got=%h exp=ffff", WrCnt);
    end
    step(g);
    ExValid = 1'b0;
    n_tests++;
    if (WrCnt !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero got=%h exp=0000", WrCnt);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      tb_rf[r] = '0;
      m_rf[r]  = '0;
    end
    m_ptr = 1'b0; m_regwr = 1'b0; m_rw = '0; m_busw = '0; m_cnt = '0;
    Rst_n = 1'b0; Hold = 1'b0;
    ExValid = 1'b0; ExRW = '0; ExBusW = '0;
    MemValid = 1'b0; MemRW = '0; MemBusW = '0;

    test_reset();
    test_single_write();
    test_round_robin();
    test_conflict();
    test_zero_reg();
    test_hold();
    test_random();
    test_wrap();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

- Shares the single register-file write port (RegWr/RW/BusW, written on negedge Clk) between two writeback requesters: EX (ALU results) and MEM (load results).
- Each requester uses a valid/ready handshake. Requests are granted round-robin, except that a same-register conflict is always resolved in favour of MEM, the older instruction.
- The granted write is registered and presented to the register file for exactly one cycle.
- The block also keeps a committed-write counter for performance tracking.

## Interface
Parameters:
- DATA_W, 64, write data width
- ADDR_W, 5, register index width

Ports:
- Clk  in  1  clock. All state updates on posedge.
- Rst_n  in  1  reset, synchronous, active-low
- Hold  in  1  stall. While 1, no request is granted.
- ExValid  in  1  EX requester has a write pending
- ExReady  out  1  EX write accepted this cycle
- ExRW  in  ADDR_W  EX destination register
- ExBusW  in  DATA_W  EX write data
- MemValid  in  1  MEM requester has a write pending
- MemReady  out  1  MEM write accepted this cycle
- MemRW  in  ADDR_W  MEM destination register
- MemBusW  in  DATA_W  MEM write data
- RegWr  out  1  register-file write enable (registered)
- RW  out  ADDR_W  register-file write index (registered)
- BusW  out  DATA_W  register-file write data (registered)
- WrCnt  out  16  count of committed writes, wraps

## Operation
- **Transfer:** a transfer occurs on a requester when Valid && Ready at a posedge. At most one transfer per cycle.
- **Protocol:** Valid, RW and BusW are held stable until the transfer. Valid must not depend on Ready.
- **Pointer state:** RrPtr, 1 bit, holds the requester with priority on the next non-conflicting contention (0 = EX, 1 = MEM).
- **Grant rules** (Ready is combinational, from Valid, RW, RrPtr, Hold and Rst_n):
  - Rst_n=0 or Hold=1: no grant.
  - Exactly one Valid: grant it.
  - Both Valid and ExRW == MemRW: grant MEM.
  - Both Valid, different RW: grant RrPtr.
  - Neither Valid: no grant.
- **Pointer update:** on any grant, RrPtr becomes the non-granted requester. With no grant, RrPtr is unchanged.
- **Output register:**
  - On a transfer, RW and BusW capture the winner's RW and BusW.
  - RegWr captures 1, unless the winner's RW == 31 (zero register). Then RegWr = 0, and the transfer still completes.
  - On a cycle with no transfer, RegWr = 0, and RW and BusW keep their previous values.
- **Counter:** WrCnt increments at every edge where RegWr is registered 1. It wraps from 0xFFFF to 0x0000.

## Timing
- **Reset values:** a posedge with Rst_n=0 sets RegWr=0, RW=0, BusW=0, RrPtr=0 and WrCnt=0. ExReady and MemReady are 0 throughout reset.
- **Reset mid-operation:** no transfer occurs while Rst_n=0. A request still valid after reset is re-arbitrated with RrPtr=0.
- **Latency:**
  - A transfer at posedge k drives RegWr/RW/BusW during cycle k+1.
  - The register file writes at the negedge inside cycle k+1.
  - The new value is readable from the second half of cycle k+1.
- **Throughput:** one write per cycle. Back-to-back transfers give RegWr=1 on consecutive cycles.
- **Hold:** Hold=1 at posedge k gives RegWr=0 in cycle k+1. RrPtr is frozen while Hold=1.
- **Starvation:** under continuous dual-Valid traffic with distinct RW, grants strictly alternate.
  - Under repeated same-RW conflicts, MEM wins each time.
  - The upstream pipeline is responsible for forward progress.

## Structure
- **Package regfile_pkg** holds:
  - DATA_W and ADDR_W defaults
  - ZERO_REG = 5'd31
  - REQ_EX = 1'b0 and REQ_MEM = 1'b1
- **Sub-module rr_arb2:** a combinational two-way grant with inputs req[1:0], ptr and force_mem, and one-hot output gnt[1:0].
- The top level contains the grant gating, RrPtr, the output register and WrCnt.

## Test plan
- **Reset:** Rst_n=0 for 2 cycles with both Valid high. Expect ExReady = MemReady = 0, RegWr = 0 and WrCnt = 0. After release, EX (RrPtr=0) is granted first.
- **Single write:** ExValid with ExRW=3, ExBusW=0x0123456789ABCDEF. Expect ExReady=1 in that cycle, then RegWr=1, RW=3 and BusW=0x0123456789ABCDEF in the next cycle. Reading reg 3 returns the value after that negedge, and WrCnt=1.
- **Round-robin:** both Valid continuously, ExRW=1 and MemRW=2, with each winner presenting a new request after its transfer. Expect the grant sequence EX, MEM, EX, MEM; RW sequence 1, 2, 1, 2 on consecutive cycles; and RegWr held at 1.
- **Conflict:** both Valid with ExRW = MemRW = 7 and RrPtr=0. Expect MemReady=1 and RW=7 with MEM's data. EX is granted the following cycle, so EX's data is the final value of reg 7.
- **Zero register:** MemValid with MemRW=31 and data 0xFF. Expect MemReady=1, RegWr=0 next cycle, WrCnt unchanged, and reg 31 still reads 0.
- **Hold and wrap:** Hold=1 for 3 cycles with EX Valid. Expect ExReady=0 and RegWr=0 throughout, and EX granted on the first cycle after Hold drops. Separately, 65536 committed writes return WrCnt to 0.
